cv32e40p_load_store_unit: RTL and testbench
===========================================

CV32E40P_LOAD_STORE_UNIT -- requirements
Module: cv32e40p_load_store_unit

Interface
REQ-001 The block SHALL have no parameters; address and data widths SHALL be fixed at 32 bits.
REQ-002 The block SHALL have the following ports, one per line:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_req_ex_i  in  1  EX requests a memory access this cycle.
- data_addr_ex_i  in  32  byte address.
- data_we_ex_i  in  1  1=store, 0=load.
- data_type_ex_i  in  2  access size: 00 word, 01 half, 10 byte.
- data_sign_ext_ex_i  in  1  sign-extend load result.
- data_wdata_ex_i  in  32  store data, LSB-aligned.
- lsu_ready_ex_o  out  1  LSU accepts a new request this cycle.
- lsu_rdata_o  out  32  aligned/extended load data.
- lsu_rvalid_o  out  1  load/store response complete, 1-cycle pulse.
- lsu_err_o  out  1  bus error on completing access, qualified by lsu_rvalid_o.
- lsu_misaligned_o  out  1  rejected misaligned request, 1-cycle pulse.
- busy_o  out  1  transaction outstanding.
- data_req_o  out  1  bus request.
- data_gnt_i  in  1  bus grant.
- data_addr_o  out  32  word-aligned bus address.
- data_we_o  out  1  bus write enable.
- data_be_o  out  4  byte enables.
- data_wdata_o  out  32  lane-replicated store data.
- data_rvalid_i  in  1  bus response valid.
- data_rdata_i  in  32  bus read data.
- data_err_i  in  1  bus error, qualified by data_rvalid_i.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT_GNT and WAIT_RVALID, with at most one outstanding transaction.
REQ-004 Request acceptance: a request SHALL be accepted when data_req_ex_i && lsu_ready_ex_o && aligned, where lsu_ready_ex_o = (IDLE) | (WAIT_RVALID & data_rvalid_i).
REQ-005 Alignment: word accesses SHALL be aligned when addr[1:0]=00, half when addr[0]=0, byte always.
REQ-006 Misaligned request: the LSU SHALL pulse lsu_misaligned_o in the same cycle, SHALL NOT assert data_req_o, and SHALL leave the state unchanged.
REQ-007 On acceptance, data_req_o SHALL assert combinationally in the same cycle. If data_gnt_i=1 the FSM SHALL go to WAIT_RVALID; otherwise it SHALL go to WAIT_GNT.
REQ-008 On acceptance the LSU SHALL latch addr, we, type, sign_ext, wdata and addr[1:0]. In WAIT_GNT, data_req_o SHALL stay 1 and all bus outputs SHALL stay stable from the latched values until data_gnt_i.
REQ-009 data_addr_o SHALL equal {addr[31:2],2'b00}.
REQ-010 Byte enables SHALL be: word 1111; half 0011 or 1100 by addr[1]; byte 0001<<addr[1:0].
REQ-011 Store data SHALL be replicated: byte wdata[7:0] x4; half wdata[15:0] x2; word unchanged.
REQ-012 In WAIT_RVALID, on data_rvalid_i the LSU SHALL pulse lsu_rvalid_o with lsu_err_o=data_err_i in the same cycle (combinational), and the FSM SHALL return to IDLE unless a new request is accepted that cycle (back-to-back, REQ-007 applies).
REQ-013 Load data: the LSU SHALL select data_rdata_i lane by the latched offset and type, then zero- or sign-extend to 32 bits. lsu_rdata_o SHALL be 0 for stores and when lsu_rvalid_o=0.
REQ-014 data_rvalid_i outside WAIT_RVALID and data_gnt_i outside a request SHALL be ignored.
REQ-015 busy_o SHALL be 1 in WAIT_GNT and WAIT_RVALID.
REQ-016 Bus errors SHALL NOT stall the FSM; the error is reported only.

Reset
REQ-017 On rst_n low, asynchronously: state=IDLE, all latched fields=0, all outputs 0 except lsu_ready_ex_o=1.
REQ-018 Reset asserted mid-transaction SHALL abandon the transaction, and a late data_rvalid_i after reset SHALL be ignored.

Structure
REQ-019 The data_type encoding (lsu_type_e) and the FSM state enum (lsu_state_e) SHALL live in cv32e40p_pkg.
REQ-020 The block SHALL be a single module with no sub-modules.

Verification
REQ-021 LW addr 0x1000, gnt same cycle, rvalid next cycle, rdata 0xDEADBEEF -> addr_o 0x1000, be 1111, lsu_rdata_o 0xDEADBEEF one cycle after request.
REQ-022 LB sign_ext addr 0x1003, rdata 0x80FF_0000 -> be 1000, lsu_rdata_o 0xFFFFFF80; repeated with LBU -> 0x00000080.
REQ-023 SH addr 0x2002, wdata 0x0000ABCD, gnt held low 3 cycles -> req held 4 cycles, stable addr 0x2000, be 1100, wdata_o 0xABCDABCD.
REQ-024 LW addr 0x1001 -> lsu_misaligned_o pulse, no data_req_o, state IDLE.
REQ-025 Back-to-back LW 0x10 then LW 0x14, second request in the rvalid cycle -> second data_req_o in that same cycle, no idle bubble.
REQ-026 rst_n low during WAIT_RVALID, then rvalid pulse after release -> no lsu_rvalid_o, state IDLE.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg
//   Shared types and helpers for the load/store unit:
//   - lsu_type_e  : access size encoding carried on data_type_ex_i
//   - lsu_state_e : LSU FSM state
//   - lsu_aligned / lsu_be / lsu_wdata / lsu_rdata : pure datapath helpers
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_type_e;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_GNT    = 2'b01,
        WAIT_RVALID = 2'b10
    } lsu_state_e;

    // Encoding 2'b11 is undefined; it is treated as a word access throughout.
    function automatic logic lsu_aligned(input logic [1:0] dtype, input logic [1:0] off);
        case (dtype)
            LSU_HALF: lsu_aligned = ~off[0];
            LSU_BYTE: lsu_aligned = 1'b1;
            default:  lsu_aligned = (off == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lsu_be(input logic [1:0] dtype, input logic [1:0] off);
        case (dtype)
            LSU_HALF: lsu_be = off[1] ? 4'b1100 : 4'b0011;
            LSU_BYTE: lsu_be = 4'b0001 << off;
            default:  lsu_be = 4'b1111;
        endcase
    endfunction

    // Replicate store data across lanes so the byte enables pick the right copy.
    function automatic logic [31:0] lsu_wdata(input logic [1:0] dtype, input logic [31:0] wdata);
        case (dtype)
            LSU_HALF: lsu_wdata = {2{wdata[15:0]}};
            LSU_BYTE: lsu_wdata = {4{wdata[7:0]}};
            default:  lsu_wdata = wdata;
        endcase
    endfunction

    // Pick the addressed lane out of the bus word and extend it to 32 bits.
    function automatic logic [31:0] lsu_rdata(input logic [1:0] dtype, input logic [1:0] off,
                                              input logic sext, input logic [31:0] rdata);
        logic [15:0] h;
        logic [7:0]  b;
        h = off[1] ? rdata[31:16] : rdata[15:0];
        b = rdata[8*off +: 8];
        case (dtype)
            LSU_HALF: lsu_rdata = {{16{sext & h[15]}}, h};
            LSU_BYTE: lsu_rdata = {{24{sext & b[7]}}, b};
            default:  lsu_rdata = rdata;
        endcase
    endfunction

endpackage

// File: rtl/cv32e40p_load_store_unit.sv
// cv32e40p_load_store_unit
//   Single-outstanding load/store unit between the EX stage and an OBI-like
//   data bus (req/gnt address phase, rvalid response phase).
//   EX side : data_req_ex_i, data_addr_ex_i, data_we_ex_i, data_type_ex_i,
//             data_sign_ext_ex_i, data_wdata_ex_i -> lsu_ready_ex_o,
//             lsu_rdata_o, lsu_rvalid_o, lsu_err_o, lsu_misaligned_o, busy_o
//   Bus side: data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
//             data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
//   A new request may be accepted in the cycle the previous response returns,
//   so back-to-back accesses issue with no idle bubble.
module cv32e40p_load_store_unit
    import cv32e40p_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        data_req_ex_i,
    input  logic [31:0] data_addr_ex_i,
    input  logic        data_we_ex_i,
    input  logic [1:0]  data_type_ex_i,
    input  logic        data_sign_ext_ex_i,
    input  logic [31:0] data_wdata_ex_i,

    output logic        lsu_ready_ex_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rvalid_o,
    output logic        lsu_err_o,
    output logic        lsu_misaligned_o,
    output logic        busy_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    lsu_state_e  state_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  type_q;
    logic        sext_q;
    logic [31:0] wdata_q;

    logic        aligned;
    logic        accept;
    logic        resp;

    // Bus fields come straight from EX in the accepting cycle, otherwise from
    // the latched copy so they hold steady while waiting for the grant.
    logic [31:0] src_addr;
    logic        src_we;
    logic [1:0]  src_type;
    logic [31:0] src_wdata;

    always_comb begin
        aligned          = lsu_aligned(data_type_ex_i, data_addr_ex_i[1:0]);
        lsu_ready_ex_o   = (state_q == IDLE) || ((state_q == WAIT_RVALID) && data_rvalid_i);
        accept           = data_req_ex_i && lsu_ready_ex_o && aligned;
        lsu_misaligned_o = data_req_ex_i && lsu_ready_ex_o && !aligned;
        resp             = (state_q == WAIT_RVALID) && data_rvalid_i;
        busy_o           = (state_q != IDLE);

        src_addr  = accept ? data_addr_ex_i  : addr_q;
        src_we    = accept ? data_we_ex_i    : we_q;
        src_type  = accept ? data_type_ex_i  : type_q;
        src_wdata = accept ? data_wdata_ex_i : wdata_q;

        data_req_o   = accept || (state_q == WAIT_GNT);
        data_addr_o  = 32'h0;
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_wdata_o = 32'h0;
        if (data_req_o) begin
            data_addr_o  = {src_addr[31:2], 2'b00};
            data_we_o    = src_we;
            data_be_o    = lsu_be(src_type, src_addr[1:0]);
            data_wdata_o = lsu_wdata(src_type, src_wdata);
        end

        // Response is decoded with the fields of the completing access; the
        // latches only take the new request's fields at the clock edge.
        lsu_rvalid_o = resp;
        lsu_err_o    = resp && data_err_i;
        lsu_rdata_o  = (resp && !we_q) ? lsu_rdata(type_q, addr_q[1:0], sext_q, data_rdata_i) : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            type_q  <= 2'b00;
            sext_q  <= 1'b0;
            wdata_q <= 32'h0;
        end else begin
            if (accept) begin
                addr_q  <= data_addr_ex_i;
                we_q    <= data_we_ex_i;
                type_q  <= data_type_ex_i;
                sext_q  <= data_sign_ext_ex_i;
                wdata_q <= data_wdata_ex_i;
            end
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
                WAIT_GNT: begin
                    if (data_gnt_i) state_q <= WAIT_RVALID;
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        if (accept) state_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                        else        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_load_store_unit.sv
module tb_cv32e40p_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_req_ex_i = 1'b0;
    logic [31:0] data_addr_ex_i = '0;
    logic        data_we_ex_i = 1'b0;
    logic [1:0]  data_type_ex_i = '0;
    logic        data_sign_ext_ex_i = 1'b0;
    logic [31:0] data_wdata_ex_i = '0;
    logic        lsu_ready_ex_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rvalid_o;
    logic        lsu_err_o;
    logic        lsu_misaligned_o;
    logic        busy_o;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic        data_err_i = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] rdata; logic err; } resp_t;
    resp_t sb[$];

    cv32e40p_load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_ex_i(data_req_ex_i), .data_addr_ex_i(data_addr_ex_i),
        .data_we_ex_i(data_we_ex_i), .data_type_ex_i(data_type_ex_i),
        .data_sign_ext_ex_i(data_sign_ext_ex_i), .data_wdata_ex_i(data_wdata_ex_i),
        .lsu_ready_ex_o(lsu_ready_ex_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_err_o(lsu_err_o),
        .lsu_misaligned_o(lsu_misaligned_o), .busy_o(busy_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .data_err_i(data_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 3 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_req(input logic we, input logic [1:0] t, input logic [31:0] a,
                          input logic sx, input logic [31:0] wd);
        data_req_ex_i      = 1'b1;
        data_we_ex_i       = we;
        data_type_ex_i     = t;
        data_addr_ex_i     = a;
        data_sign_ext_ex_i = sx;
        data_wdata_ex_i    = wd;
    endtask

    task automatic ex_idle();
        data_req_ex_i  = 1'b0;
        data_addr_ex_i = 32'hFFFF_FFFF;
        data_type_ex_i = 2'b00;
        data_we_ex_i   = 1'b0;
        data_wdata_ex_i = 32'h5A5A_5A5A;
    endtask

    task automatic push(input logic [31:0] rd, input logic e);
        resp_t r;
        r.rdata = rd;
        r.err   = e;
        sb.push_back(r);
    endtask

    // Scoreboard: every response the DUT produces must match the oldest expected one.
    always @(negedge clk) begin
        if (lsu_rvalid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                resp_t r;
                r = sb.pop_front();
                chk("sb_rdata", lsu_rdata_o, r.rdata);
                chk("sb_err", {31'b0, lsu_err_o}, {31'b0, r.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Load with grant in the request cycle and response on the next cycle.
    task automatic load1(input logic [1:0] t, input logic [31:0] a, input logic sx,
                         input logic [3:0] be, input logic [31:0] bus_rd, input logic [31:0] exp_rd);
        step();
        ex_req(1'b0, t, a, sx, 32'h0);
        data_gnt_i = 1'b1;
        push(exp_rd, 1'b0);
        #3;
        chk("ld_req", {31'b0, data_req_o}, 32'd1);
        chk("ld_addr", data_addr_o, {a[31:2], 2'b00});
        chk("ld_be", {28'b0, data_be_o}, {28'b0, be});
        step();
        ex_idle();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = bus_rd;
        #3;
        chk("ld_rvalid", {31'b0, lsu_rvalid_o}, 32'd1);
        chk("ld_req_off", {31'b0, data_req_o}, 32'd0);
        step();
        data_rvalid_i = 1'b0;
        #3;
        chk("ld_idle_busy", {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        ex_idle();
        #3;
        chk("rst_ready", {31'b0, lsu_ready_ex_o}, 32'd1);
        chk("rst_req", {31'b0, data_req_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_rdata", lsu_rdata_o, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;

        // Aligned loads of each size and extension mode.
        load1(2'b00, 32'h0000_1000, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load1(2'b10, 32'h0000_1003, 1'b1, 4'b1000, 32'h80FF_0000, 32'hFFFF_FF80);
        load1(2'b10, 32'h0000_1003, 1'b0, 4'b1000, 32'h80FF_0000, 32'h0000_0080);
        load1(2'b01, 32'h0000_1002, 1'b1, 4'b1100, 32'h8001_7F00, 32'hFFFF_8001);
        load1(2'b01, 32'h0000_1000, 1'b0, 4'b0011, 32'h1234_9ABC, 32'h0000_9ABC);
        load1(2'b10, 32'h0000_1001, 1'b1, 4'b0010, 32'h0000_7F00, 32'h0000_007F);

        // Store half with grant withheld for 3 cycles; bus fields must hold.
        step();
        ex_req(1'b1, 2'b01, 32'h0000_2002, 1'b0, 32'h0000_ABCD);
        data_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) data_gnt_i = 1'b1;
            #3;
            chk("sh_req", {31'b0, data_req_o}, 32'd1);
            chk("sh_addr", data_addr_o, 32'h0000_2000);
            chk("sh_be", {28'b0, data_be_o}, 32'hC);
            chk("sh_wdata", data_wdata_o, 32'hABCD_ABCD);
            chk("sh_we", {31'b0, data_we_o}, 32'd1);
            if (i > 0) chk("sh_ready", {31'b0, lsu_ready_ex_o}, 32'd0);
            step();
            ex_idle();
        end
        data_gnt_i = 1'b0;
        #3;
        chk("sh_req_drop", {31'b0, data_req_o}, 32'd0);
        chk("sh_busy", {31'b0, busy_o}, 32'd1);
        step();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hCAFE_F00D;
        data_err_i    = 1'b1;
        push(32'h0, 1'b1);
        step();
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        #3;
        chk("sh_done_busy", {31'b0, busy_o}, 32'd0);

        // Misaligned word load is rejected without touching the bus.
        step();
        ex_req(1'b0, 2'b00, 32'h0000_1001, 1'b0, 32'h0);
        data_gnt_i = 1'b1;
        #3;
        chk("mis_pulse", {31'b0, lsu_misaligned_o}, 32'd1);
        chk("mis_noreq", {31'b0, data_req_o}, 32'd0);
        step();
        ex_idle();
        data_gnt_i = 1'b0;
        #3;
        chk("mis_idle_busy", {31'b0, busy_o}, 32'd0);
        chk("mis_pulse_end", {31'b0, lsu_misaligned_o}, 32'd0);
        chk("mis_ready", {31'b0, lsu_ready_ex_o}, 32'd1);

        // Back-to-back loads: second request issues in the first's rvalid cycle.
        step();
        ex_req(1'b0, 2'b00, 32'h0000_0010, 1'b0, 32'h0);
        data_gnt_i = 1'b1;
        push(32'h1111_1111, 1'b0);
        step();
        ex_req(1'b0, 2'b00, 32'h0000_0014, 1'b0, 32'h0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1111_1111;
        push(32'h2222_2222, 1'b0);
        #3;
        chk("b2b_ready", {31'b0, lsu_ready_ex_o}, 32'd1);
        chk("b2b_req", {31'b0, data_req_o}, 32'd1);
        chk("b2b_addr", data_addr_o, 32'h0000_0014);
        step();
        ex_idle();
        data_gnt_i   = 1'b0;
        data_rdata_i = 32'h2222_2222;
        #3;
        chk("b2b_busy", {31'b0, busy_o}, 32'd1);
        step();
        data_rvalid_i = 1'b0;
        #3;
        chk("b2b_idle", {31'b0, busy_o}, 32'd0);

        // Reset during WAIT_RVALID; a late response must be dropped.
        step();
        ex_req(1'b0, 2'b00, 32'h0000_0020, 1'b0, 32'h0);
        data_gnt_i = 1'b1;
        step();
        ex_idle();
        data_gnt_i = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("rstmid_busy", {31'b0, busy_o}, 32'd0);
        chk("rstmid_ready", {31'b0, lsu_ready_ex_o}, 32'd1);
        step();
        rst_n = 1'b1;
        step();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h3333_3333;
        #3;
        chk("late_rvalid", {31'b0, lsu_rvalid_o}, 32'd0);
        chk("late_rdata", lsu_rdata_o, 32'h0);
        step();
        data_rvalid_i = 1'b0;
        #3;
        chk("late_busy", {31'b0, busy_o}, 32'd0);

        step();
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
